// File: rtl/data_mem_responder.sv
// Multi-channel data-memory responder: single-port array, round-robin arbitration,
// per-requester IDLE/LAT/RESP handshake FSMs and a host backdoor port.
module data_mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [NUM_CHANNELS-1:0] data_mem_read_valid,
    input  logic [ADDR_BITS-1:0]    data_mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] data_mem_read_ready,
    output logic [DATA_BITS-1:0]    data_mem_read_data [NUM_CHANNELS],

    input  logic [NUM_CHANNELS-1:0] data_mem_write_valid,
    input  logic [ADDR_BITS-1:0]    data_mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    data_mem_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] data_mem_write_ready,

    input  logic                 host_write_enable,
    input  logic [ADDR_BITS-1:0] host_address,
    input  logic [DATA_BITS-1:0] host_write_data,
    output logic [DATA_BITS-1:0] host_read_data
);

    localparam int REQ   = 2 * NUM_CHANNELS;
    localparam int PW    = (REQ > 1) ? $clog2(REQ) : 1;
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAT  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q [REQ];
    state_t          state_d [REQ];
    logic [3:0]      cnt_q   [REQ];
    logic [3:0]      cnt_d   [REQ];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;

    logic [REQ-1:0]  req_valid;
    logic [REQ-1:0]  eligible;
    logic [REQ-1:0]  grant;
    logic            granted;
    logic [PW-1:0]   idx;

    logic                 acc_we;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [DATA_BITS-1:0] acc_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    logic [DATA_BITS-1:0] mem     [DEPTH];
    logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS];

    // Index order: reads first, then writes
    assign req_valid = {data_mem_write_valid, data_mem_read_valid};

    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            eligible[i] = req_valid[i] && (state_q[i] == IDLE);
        end
    end

    // Host writes and reset both block arbitration for the edge
    always_comb begin
        grant   = '0;
        granted = 1'b0;
        ptr_d   = ptr_q;
        idx     = '0;
        if (!reset && !host_write_enable) begin
            for (int k = 0; k < REQ; k++) begin
                idx = PW'((int'(ptr_q) + k) % REQ);
                if (!granted && eligible[idx]) begin
                    grant[idx] = 1'b1;
                    granted    = 1'b1;
                    ptr_d      = (int'(idx) == REQ - 1) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_we    = host_write_enable;
        acc_addr  = host_address;
        acc_wdata = host_write_data;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant[i]) begin
                acc_addr = data_mem_read_address[i];
            end
            if (grant[NUM_CHANNELS + i]) begin
                acc_we    = 1'b1;
                acc_addr  = data_mem_write_address[i];
                acc_wdata = data_mem_write_data[i];
            end
        end
    end

    // Single shared access port; contents survive reset
    assign mem_rdata      = mem[acc_addr];
    assign host_read_data = mem[host_address];

    always_ff @(posedge clk) begin
        if (acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (grant[i]) begin
                        if (LATENCY > 1) begin
                            state_d[i] = LAT;
                            cnt_d[i]   = LAT_INIT;
                        end else begin
                            state_d[i] = RESP;
                        end
                    end
                end
                LAT: begin
                    if (cnt_q[i] <= 4'd1) begin
                        state_d[i] = RESP;
                        cnt_d[i]   = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 4'd1;
                    end
                end
                RESP: begin
                    state_d[i] = IDLE;
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            for (int i = 0; i < REQ; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < REQ; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (grant[i]) begin
                    rdata_q[i] <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            data_mem_read_ready[i]  = (state_q[i] == RESP);
            data_mem_write_ready[i] = (state_q[NUM_CHANNELS + i] == RESP);
            data_mem_read_data[i]   = rdata_q[i];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 1, 3, 4) share
// stimulus and are checked every cycle against a timestamp-based model.
module tb_data_mem_responder;

    localparam int NI = 3;
    localparam int NC = 4;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] rv [NI];
    logic [3:0] wv [NI];
    logic [7:0] raddr [NC];
    logic [7:0] waddr [NC];
    logic [7:0] wdata [NC];
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hwd;

    logic [3:0] rrdy [NI];
    logic [3:0] wrdy [NI];
    logic [7:0] rdd  [NI][NC];
    logic [7:0] hrd  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_BITS(8),
            .DATA_BITS(8),
            .NUM_CHANNELS(4),
            .LATENCY((g == 0) ? 1 : g + 2)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .data_mem_read_valid(rv[g]),
            .data_mem_read_address(raddr),
            .data_mem_read_ready(rrdy[g]),
            .data_mem_read_data(rdd[g]),
            .data_mem_write_valid(wv[g]),
            .data_mem_write_address(waddr),
            .data_mem_write_data(wdata),
            .data_mem_write_ready(wrdy[g]),
            .host_write_enable(hwe),
            .host_address(haddr),
            .host_write_data(hwd),
            .host_read_data(hrd[g])
        );
    end

    int vectors = 0;
    int miscompares = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int m);
        return (m == 0) ? 1 : m + 2;
    endfunction

    // Model: memory image, grant timestamps, round-robin pointer
    logic [7:0] mmem [NI][256];
    bit         mk   [NI][256];
    bit         act  [NI][NR];
    int         respe[NI][NR];
    int         mptr [NI];
    logic [7:0] mrd  [NI][NC];
    bit         mrk  [NI][NC];
    logic [7:0] erdy [NI];
    logic [7:0] seen [NI];
    int         cyc = 0;

    always @(posedge clk) begin
        int gi;
        int ix;
        bit v;
        cyc = cyc + 1;
        for (int m = 0; m < NI; m++) begin
            gi = -1;
            if (hwe) begin
                mmem[m][haddr] = hwd;
                mk[m][haddr]   = 1'b1;
            end
            if (reset) begin
                mptr[m] = 0;
                for (int i = 0; i < NR; i++) act[m][i] = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    mrd[m][c] = 8'h00;
                    mrk[m][c] = 1'b1;
                end
            end else if (!hwe) begin
                for (int k = 0; k < NR; k++) begin
                    ix = (mptr[m] + k) % NR;
                    if (ix < NC) v = rv[m][ix];
                    else         v = wv[m][ix - NC];
                    // busy from grant until the edge that ends the ready cycle
                    if (gi < 0 && v && !(act[m][ix] && cyc <= respe[m][ix] + 1))
                        gi = ix;
                end
                if (gi >= 0) begin
                    act[m][gi]   = 1'b1;
                    respe[m][gi] = cyc + lat_of(m) - 1;
                    if (gi < NC) begin
                        mrd[m][gi] = mmem[m][raddr[gi]];
                        mrk[m][gi] = mk[m][raddr[gi]];
                    end else begin
                        mmem[m][waddr[gi - NC]] = wdata[gi - NC];
                        mk[m][waddr[gi - NC]]   = 1'b1;
                    end
                    mptr[m] = (gi + 1) % NR;
                end
            end
            for (int i = 0; i < NR; i++)
                erdy[m][i] = act[m][i] && (respe[m][i] == cyc);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int m = 0; m < NI; m++) begin
                chk($sformatf("ready[%0d]", m),
                    32'({wrdy[m], rrdy[m]}), 32'(erdy[m]));
                for (int c = 0; c < NC; c++)
                    if (mrk[m][c])
                        chk($sformatf("rdata[%0d][%0d]", m, c),
                            32'(rdd[m][c]), 32'(mrd[m][c]));
                if (mk[m][haddr])
                    chk($sformatf("host_rd[%0d]", m),
                        32'(hrd[m]), 32'(mmem[m][haddr]));
            end
        end
    end

    // Requesters drop valid on the edge after they see ready
    task automatic tick();
        @(posedge clk);
        #1;
        for (int m = 0; m < NI; m++) begin
            rv[m]   = rv[m] & ~seen[m][3:0];
            wv[m]   = wv[m] & ~seen[m][7:4];
            seen[m] = erdy[m];
        end
    endtask

    task automatic wait_idle();
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 40) begin
            busy = 1'b0;
            for (int m = 0; m < NI; m++)
                if (rv[m] != 4'h0 || wv[m] != 4'h0) busy = 1'b1;
            if (busy) begin
                tick();
                n++;
            end
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: requests still pending after %0d cycles", n);
        end
        tick();
    endtask

    task automatic set_rd(input int c, input logic [7:0] a);
        for (int m = 0; m < NI; m++) rv[m][c] = 1'b1;
        raddr[c] = a;
    endtask

    task automatic set_wr(input int c, input logic [7:0] a, input logic [7:0] d);
        for (int m = 0; m < NI; m++) wv[m][c] = 1'b1;
        waddr[c] = a;
        wdata[c] = d;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        hwe = 1'b1;
        haddr = a;
        hwd = d;
        tick();
        hwe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        hwe = 1'b0;
        haddr = 8'h00;
        hwd = 8'h00;
        for (int m = 0; m < NI; m++) begin
            rv[m] = 4'h0;
            wv[m] = 4'h0;
            seen[m] = 8'h00;
        end
        for (int c = 0; c < NC; c++) begin
            raddr[c] = 8'h00;
            waddr[c] = 8'h00;
            wdata[c] = 8'h00;
        end
        tick();
        tick();
        cmp_on = 1'b1;
        for (int m = 0; m < NI; m++) begin
            chk("reset_rrdy", 32'(rrdy[m]), 32'h0);
            chk("reset_wrdy", 32'(wrdy[m]), 32'h0);
            for (int c = 0; c < NC; c++)
                chk("reset_rdata", 32'(rdd[m][c]), 32'h0);
        end
        reset = 1'b0;

        // Single read after host preload
        host_wr(8'h05, 8'h07);
        for (int m = 0; m < NI; m++) chk("host_preload", 32'(hrd[m]), 32'h07);
        set_rd(0, 8'h05);
        tick();
        chk("single_rdy", 32'(rrdy[0]), 32'h1);
        chk("single_data", 32'(rdd[0][0]), 32'h07);
        tick();
        chk("single_no_repeat", 32'(rrdy[0]), 32'h0);
        wait_idle();

        // Four simultaneous reads from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) host_wr(8'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) set_rd(i, 8'(i));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_rdy", 32'(rrdy[0]), 32'(1 << k));
            chk("rr_data", 32'(rdd[0][k]), 32'(k + 1));
        end
        wait_idle();

        // Same-address read and write raised together
        do_reset();
        host_wr(8'h09, 8'h11);
        set_rd(0, 8'h09);
        set_wr(0, 8'h09, 8'h55);
        tick();
        chk("rw_read_rdy", 32'(rrdy[0]), 32'h1);
        chk("rw_read_old", 32'(rdd[0][0]), 32'h11);
        chk("rw_write_not_yet", 32'(wrdy[0]), 32'h0);
        tick();
        chk("rw_write_rdy", 32'(wrdy[0]), 32'h1);
        chk("rw_read_done", 32'(rrdy[0]), 32'h0);
        chk("rw_host_new", 32'(hrd[0]), 32'h55);
        wait_idle();
        set_rd(1, 8'h09);
        tick();
        chk("rw_reread_rdy", 32'(rrdy[0]), 32'h2);
        chk("rw_reread_data", 32'(rdd[0][1]), 32'h55);
        wait_idle();

        // Write on channel 2, watched on the LATENCY=3 instance
        haddr = 8'hFF;
        set_wr(2, 8'hFF, 8'hA5);
        tick();
        chk("lat1_wrdy", 32'(wrdy[0]), 32'h4);
        chk("lat3_wrdy_e0", 32'(wrdy[1]), 32'h0);
        chk("lat3_host", 32'(hrd[1]), 32'hA5);
        tick();
        chk("lat3_wrdy_e1", 32'(wrdy[1]), 32'h0);
        tick();
        chk("lat3_wrdy_e2", 32'(wrdy[1]), 32'h4);
        wait_idle();

        // Host writes hold off a pending read
        set_rd(1, 8'h03);
        hwe = 1'b1;
        haddr = 8'h20;
        hwd = 8'h99;
        tick();
        chk("host_block1", 32'(rrdy[0]), 32'h0);
        tick();
        chk("host_block2", 32'(rrdy[0]), 32'h0);
        chk("host_block_mem", 32'(hrd[0]), 32'h99);
        hwe = 1'b0;
        tick();
        chk("host_after_rdy", 32'(rrdy[0]), 32'h2);
        chk("host_after_data", 32'(rdd[0][1]), 32'h04);
        wait_idle();

        // Reset while channel 3 sits in LAT on the LATENCY=4 instance
        set_rd(3, 8'h00);
        tick();
        chk("rst_lat1_rdy", 32'(rrdy[0]), 32'h8);
        tick();
        reset = 1'b1;
        rv[1][3] = 1'b0;
        rv[2][3] = 1'b0;
        tick();
        for (int m = 0; m < NI; m++) begin
            chk("rst_rrdy", 32'(rrdy[m]), 32'h0);
            chk("rst_wrdy", 32'(wrdy[m]), 32'h0);
            for (int c = 0; c < NC; c++)
                chk("rst_rdata", 32'(rdd[m][c]), 32'h0);
        end
        reset = 1'b0;
        haddr = 8'h05;
        #1;
        chk("rst_keep5", 32'(hrd[2]), 32'h07);
        haddr = 8'h09;
        #1;
        chk("rst_keep9", 32'(hrd[2]), 32'h55);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_no_pulse", 32'(rrdy[2]), 32'h0);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
